// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter (option: BIN2BCD_BLANK_EN)
module bin2bcd_seq #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             key0,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bin,
   output logic             out_valid,
   output logic [3:0]       bcd_hund,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones
);

   localparam int SRW = WIDTH + 12;
   localparam int CW  = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BIN2BCD_BLANK_EN
   localparam logic [3:0] RST_LEAD = 4'hF;
`else
   localparam logic [3:0] RST_LEAD = 4'h0;
`endif

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   iter;
   logic [SRW-1:0]  sr, sr_adj, sr_nxt;
   logic            last_iter;
   logic [3:0]      raw_h, raw_t, raw_o;
   logic [3:0]      dig_h, dig_t, dig_o;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // one double-dabble iteration: correct each BCD nibble, then shift the whole register
   always_comb begin
      sr_adj = sr;
      sr_adj[SRW-1 -: 4] = add3(sr[SRW-1 -: 4]);
      sr_adj[SRW-5 -: 4] = add3(sr[SRW-5 -: 4]);
      sr_adj[SRW-9 -: 4] = add3(sr[SRW-9 -: 4]);
      sr_nxt = sr_adj << 1;
   end

   // digits produced by the final iteration, with optional leading-zero blanking
   always_comb begin
      raw_h = sr_nxt[SRW-1 -: 4];
      raw_t = sr_nxt[SRW-5 -: 4];
      raw_o = sr_nxt[SRW-9 -: 4];
      dig_o = raw_o;
`ifdef BIN2BCD_BLANK_EN
      dig_h = (raw_h == 4'd0) ? 4'hF : raw_h;
      dig_t = (raw_h == 4'd0 && raw_t == 4'd0) ? 4'hF : raw_t;
`else
      dig_h = raw_h;
      dig_t = raw_t;
`endif
   end

   assign last_iter = (iter == LAST);

   // state register
   always_ff @(posedge clk or negedge key0) begin
      if (!key0) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic and handshake output
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_iter) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: load on accept, iterate while shifting, publish digits on the last iteration
   always_ff @(posedge clk or negedge key0) begin
      if (!key0) begin
         sr        <= '0;
         iter      <= '0;
         out_valid <= 1'b0;
         bcd_hund  <= RST_LEAD;
         bcd_tens  <= RST_LEAD;
         bcd_ones  <= 4'd0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sr   <= {12'b0, in_bin};
                  iter <= '0;
               end
            end
            SHIFT: begin
               sr   <= sr_nxt;
               iter <= iter + CW'(1);
               if (last_iter) begin
                  out_valid <= 1'b1;
                  bcd_hund  <= dig_h;
                  bcd_tens  <= dig_t;
                  bcd_ones  <= dig_o;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

   logic       clk = 1'b0;
   logic       key0;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_bin;
   logic       out_valid;
   logic [3:0] bcd_hund, bcd_tens, bcd_ones;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef BIN2BCD_BLANK_EN
   localparam logic [3:0] Z = 4'hF;
`else
   localparam logic [3:0] Z = 4'h0;
`endif

   bin2bcd_seq #(.WIDTH(7)) dut (
      .clk(clk), .key0(key0), .in_valid(in_valid), .in_ready(in_ready),
      .in_bin(in_bin), .out_valid(out_valid),
      .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
   );

   always #5 clk = ~clk;

   // wait (bounded) for out_valid after an accept edge; lat = edges counted
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
   endtask

   // present one value for a single cycle, then wait for the result
   task automatic run_conv(input logic [6:0] v, output int lat);
      @(negedge clk);
      in_bin = v; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(lat);
   endtask

   task automatic test_reset;
      key0 = 1'b0; in_valid = 1'b0; in_bin = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++; $display("FAIL reset_hs: got ready/valid=%b want 10", {in_ready, out_valid});
      end
      n_cmp++;
      if ({bcd_hund, bcd_tens, bcd_ones} !== {Z, Z, 4'd0}) begin
         n_bad++; $display("FAIL reset_digits: got %h want %h", {bcd_hund, bcd_tens, bcd_ones}, {Z, Z, 4'd0});
      end
      key0 = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      run_conv(7'd99, lat);
      n_cmp++;
      if (lat !== 7) begin n_bad++; $display("FAIL lat_99: got %0d want 7", lat); end
      n_cmp++;
      if ({bcd_hund, bcd_tens, bcd_ones} !== {Z, 4'd9, 4'd9}) begin
         n_bad++; $display("FAIL dig_99: got %h want %h", {bcd_hund, bcd_tens, bcd_ones}, {Z, 4'd9, 4'd9});
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_at_done: got %b want 1", in_ready); end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, bcd_hund, bcd_tens, bcd_ones} !== {1'b0, Z, 4'd9, 4'd9}) begin
         n_bad++; $display("FAIL hold_99: got %h want %h", {out_valid, bcd_hund, bcd_tens, bcd_ones}, {1'b0, Z, 4'd9, 4'd9});
      end
   endtask

   task automatic test_values;
      logic [6:0]  vin [3]  = '{7'd127, 7'd0, 7'd100};
      logic [11:0] vexp [3] = '{12'h127, {Z, Z, 4'd0}, 12'h100};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_conv(vin[i], lat);
         n_cmp++;
         if (lat !== 7 || {bcd_hund, bcd_tens, bcd_ones} !== vexp[i]) begin
            n_bad++;
            $display("FAIL conv_%0d: got lat=%0d dig=%h want lat=7 dig=%h", vin[i], lat, {bcd_hund, bcd_tens, bcd_ones}, vexp[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [6:0]  vin [3]  = '{7'd5, 7'd42, 7'd99};
      logic [11:0] vexp [3] = '{{Z, Z, 4'd5}, {Z, 4'd4, 4'd2}, {Z, 4'd9, 4'd9}};
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_bin = vin[0];
      @(posedge clk); #1;
      in_bin = vin[1];
      for (int i = 0; i < 3; i++) begin
         wait_done(lat);
         n_cmp++;
         if (lat !== 7 || {bcd_hund, bcd_tens, bcd_ones} !== vexp[i]) begin
            n_bad++;
            $display("FAIL b2b_%0d: got lat=%0d dig=%h want lat=7 dig=%h", i, lat, {bcd_hund, bcd_tens, bcd_ones}, vexp[i]);
         end
         if (i < 2) begin
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_%0d: in_ready got %b want 0", i, in_ready); end
            if (i == 0) in_bin = vin[2];
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_ignore_during_shift;
      int lat;
      int extra;
      @(negedge clk);
      in_bin = 7'd58; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_bin = 7'd77;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_shift: got %b want 0", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 3;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      n_cmp++;
      if (lat !== 7 || {bcd_hund, bcd_tens, bcd_ones} !== {Z, 4'd5, 4'd8}) begin
         n_bad++;
         $display("FAIL ignore: got lat=%0d dig=%h want lat=7 dig=%h", lat, {bcd_hund, bcd_tens, bcd_ones}, {Z, 4'd5, 4'd8});
      end
      extra = 0;
      repeat (12) begin @(posedge clk); #1; if (out_valid) extra++; end
      n_cmp++;
      if (extra !== 0) begin n_bad++; $display("FAIL not_queued: got %0d extra out_valid want 0", extra); end
   endtask

   task automatic test_reset_mid_shift;
      int seen;
      @(negedge clk);
      in_bin = 7'd99; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      key0 = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, bcd_hund, bcd_tens, bcd_ones} !== {2'b10, Z, Z, 4'd0}) begin
         n_bad++;
         $display("FAIL reset_mid: got %h want %h", {in_ready, out_valid, bcd_hund, bcd_tens, bcd_ones}, {2'b10, Z, Z, 4'd0});
      end
      @(negedge clk);
      key0 = 1'b1;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (out_valid) seen++; end
      n_cmp++;
      if (seen !== 0 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL after_reset_mid: got out_valid count=%0d ready=%b want 0 and 1", seen, in_ready);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_values;
      test_back_to_back;
      test_ignore_during_shift;
      test_reset_mid_shift;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
